// File: rtl/intersection_traffic_driver.sv
// -----------------------------------------------------------------------------
// intersection_traffic_driver
//
// Purpose:
//   This is the initiator side of the intersection command interface. A host
//   pushes lane commands into a small FIFO using a valid/ready handshake. Each
//   command is popped when the driver is idle, checked for legality against
//   shadow per-lane car counts, and then serialized into the simulator's
//   mode / plateIn / action strobe protocol:
//
//     mode/plateIn setup (SETUP_CYC) -> action high (PULSE_CYC)
//       -> mode/plateIn hold (HOLD_CYC)
//
//   The driver drops illegal commands and counts them. It also counts removes
//   that were issued while the lane's light was red.
//
// Parameters:
//   DEPTH      command FIFO entries (power of 2, >= 2)
//   CAP        maximum cars per lane queue
//   SETUP_CYC  cycles mode/plateIn are stable before action rises (>= 1)
//   PULSE_CYC  cycles action is held high (>= 1)
//   HOLD_CYC   cycles mode/plateIn are held after action falls (>= 1)
//
// Ports:
//   i_clk            system clock; all logic runs on the rising edge
//   i_rst            synchronous active-high reset
//   i_cmd_valid      host command valid
//   o_cmd_ready      FIFO can accept a command (registered, equals !full)
//   i_cmd_op   [1:0] 00 remA, 01 remB, 10 addA, 11 addB
//   i_cmd_plate[4:0] plate number for add ops (ignored for removes)
//   i_green_for_a    lane A light is green
//   i_green_for_b    lane B light is green
//   o_mode     [2:0] simulator mode, {1'b0, op} of the command in flight
//   o_plate_in [4:0] simulator plate input
//   o_action         simulator strobe; the simulator acts on its rising edge
//   o_busy           FSM not idle, or FIFO non-empty
//   o_rej_pulse      one-cycle pulse: a popped command was dropped
//   o_rej_count[7:0] dropped-command count (saturating)
//   o_viol_count[7:0] removes issued against a red light (saturating)
//   o_cars_a   [4:0] shadow car count, lane A
//   o_cars_b   [4:0] shadow car count, lane B
// -----------------------------------------------------------------------------
module intersection_traffic_driver #(
    parameter int DEPTH     = 4,
    parameter int CAP       = 30,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [4:0] i_cmd_plate,
    input  logic       i_green_for_a,
    input  logic       i_green_for_b,
    output logic [2:0] o_mode,
    output logic [4:0] o_plate_in,
    output logic       o_action,
    output logic       o_busy,
    output logic       o_rej_pulse,
    output logic [7:0] o_rej_count,
    output logic [7:0] o_viol_count,
    output logic [4:0] o_cars_a,
    output logic [4:0] o_cars_b
);

    // -------------------------------------------------------------------------
    // Local parameters and types
    // -------------------------------------------------------------------------
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int CYC_MAX = (SETUP_CYC > PULSE_CYC)
                             ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

    localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(DEPTH);
    localparam logic [4:0]        CAP_CARS    = 5'(CAP);
    localparam logic [CYC_W-1:0]  SETUP_LAST  = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0]  PULSE_LAST  = CYC_W'(PULSE_CYC - 1);
    localparam logic [CYC_W-1:0]  HOLD_LAST   = CYC_W'(HOLD_CYC - 1);
    localparam logic [2:0]        MODE_RESET  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    // op[1] selects add (1) or remove (0); op[0] selects lane B (1) or A (0).
    typedef struct packed {
        logic [1:0] op;
        logic [4:0] plate;
    } cmd_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    cmd_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCNT_W-1:0]  r_fifo_cnt;
    logic               r_cmd_ready;

    logic               w_push;
    logic               w_pop;
    logic [FCNT_W-1:0]  w_fifo_cnt_next;
    cmd_t               w_head;
    cmd_t               w_cmd_in;

    assign w_cmd_in = '{op: i_cmd_op, plate: i_cmd_plate};
    assign w_push   = i_cmd_valid && r_cmd_ready;
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so that no path leaves it unassigned and infers a latch.
        w_fifo_cnt_next = r_fifo_cnt;
        case ({w_push, w_pop})
            2'b10:   w_fifo_cnt_next = r_fifo_cnt + 1'b1;
            2'b01:   w_fifo_cnt_next = r_fifo_cnt - 1'b1;
            default: w_fifo_cnt_next = r_fifo_cnt;
        endcase
    end

    // NOTE: the storage array has no reset. Only the pointers and the count
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fifo_cnt  <= w_fifo_cnt_next;
            // Ready is derived from the next count. This way, a push that
            // fills the FIFO deasserts ready before the host can push again.
            r_cmd_ready <= (w_fifo_cnt_next != FIFO_FULL);
        end
    end

    // -------------------------------------------------------------------------
    // Legality check on the FIFO head
    // -------------------------------------------------------------------------
    logic       w_head_is_add;
    logic       w_head_lane_b;
    logic [4:0] w_head_cars;
    logic       w_head_legal;

    assign w_head_is_add = w_head.op[1];
    assign w_head_lane_b = w_head.op[0];
    assign w_head_cars   = w_head_lane_b ? o_cars_b : o_cars_a;
    assign w_head_legal  = w_head_is_add
                           ? ((w_head_cars != CAP_CARS) && (w_head.plate != 5'd0))
                           : (w_head_cars != 5'd0);

    // -------------------------------------------------------------------------
    // Serializer FSM
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [CYC_W-1:0]   r_cyc;
    logic [CYC_W-1:0]   w_cyc_next;
    logic               w_load;
    logic               w_reject;
    logic               w_viol;
    logic               r_action;
    logic [2:0]         r_mode;
    logic [4:0]         r_plate_in;
    logic               r_rej_pulse;
    logic [7:0]         r_rej_count;
    logic [7:0]         r_viol_count;
    logic [4:0]         r_cars_a;
    logic [4:0]         r_cars_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cyc   <= w_cyc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_reject     = 1'b0;
        w_viol       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_fifo_cnt != '0) begin
                    w_pop = 1'b1;
                    if (w_head_legal) begin
                        w_load       = 1'b1;
                        w_state_next = S_SETUP;
                        w_cyc_next   = '0;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (r_cyc == SETUP_LAST) begin
                    w_state_next = S_PULSE;
                    w_cyc_next   = '0;
                    // The light is sampled on the edge where the strobe rises.
                    // A remove (mode[1]==0) against a red light is a violation.
                    w_viol = !r_mode[1] &&
                             (r_mode[0] ? !i_green_for_b : !i_green_for_a);
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cyc == PULSE_LAST) begin
                    w_state_next = S_HOLD;
                    w_cyc_next   = '0;
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cyc == HOLD_LAST) begin
                    w_state_next = S_IDLE;
                    w_cyc_next   = '0;
                end else begin
                    w_cyc_next = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cyc_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output registers, shadow counts and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_action     <= 1'b0;
            r_mode       <= MODE_RESET;
            r_plate_in   <= '0;
            r_rej_pulse  <= 1'b0;
            r_rej_count  <= '0;
            r_viol_count <= '0;
            r_cars_a     <= '0;
            r_cars_b     <= '0;
        end else begin
            r_action    <= (w_state_next == S_PULSE);
            r_rej_pulse <= w_reject;

            if (w_reject && (r_rej_count != 8'hFF)) begin
                r_rej_count <= r_rej_count + 1'b1;
            end
            if (w_viol && (r_viol_count != 8'hFF)) begin
                r_viol_count <= r_viol_count + 1'b1;
            end

            // mode and plateIn change only on a legal pop. Between pops they
            // hold their values, which covers both the setup and hold windows.
            if (w_load) begin
                r_mode     <= {1'b0, w_head.op};
                r_plate_in <= w_head_is_add ? w_head.plate : 5'd0;
                // The legality check already keeps these within 0..CAP.
                if (w_head_lane_b) begin
                    r_cars_b <= w_head_is_add ? r_cars_b + 1'b1 : r_cars_b - 1'b1;
                end else begin
                    r_cars_a <= w_head_is_add ? r_cars_a + 1'b1 : r_cars_a - 1'b1;
                end
            end
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_mode       = r_mode;
    assign o_plate_in   = r_plate_in;
    assign o_action     = r_action;
    assign o_busy       = (r_state != S_IDLE) || (r_fifo_cnt != '0);
    assign o_rej_pulse  = r_rej_pulse;
    assign o_rej_count  = r_rej_count;
    assign o_viol_count = r_viol_count;
    assign o_cars_a     = r_cars_a;
    assign o_cars_b     = r_cars_b;

endmodule
